// File: rtl/motor602_cmd_cond.sv
// motor602_cmd_cond: synchronises, debounces and formats the seven raw motor602 panel commands.
// Build option MOTOR602_CMD_AUTOREPEAT_EN adds auto-repeat of held INC/DEC buttons.
module motor602_cmd_cond #(
    parameter int unsigned DEB_CNT = 200000,
    parameter int unsigned REP_DLY = 5000000,
    parameter int unsigned REP_PER = 1000000,
    parameter int unsigned CW      = 23
) (
    input  logic clkI,
    input  logic rstI,
    input  logic m3startI,
    input  logic m3forceStopI,
    input  logic m3invRotateI,
    input  logic m3freqINCi,
    input  logic m3freqDECi,
    input  logic m3powerINCi,
    input  logic m3powerDECi,
    output logic m3startO,
    output logic m3forceStopO,
    output logic m3invRotateO,
    output logic m3freqINCo,
    output logic m3freqDECo,
    output logic m3powerINCo,
    output logic m3powerDECo
);

    localparam int NCH      = 7;
    localparam int CH_START = 0;
    localparam int CH_FSTOP = 1;
    localparam int CH_INV   = 2;
    localparam int CH_FINC  = 3;

`ifdef MOTOR602_CMD_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIRST    = 2'd1,
        ST_WAIT_DLY = 2'd2,
        ST_REPEAT   = 2'd3
    } pair_state_e;
`else
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FIRST = 1'b1
    } pair_state_e;
`endif

    if ((DEB_CNT < 2) || (REP_DLY < 2) || (REP_PER < 1) || (CW > 31) ||
        (DEB_CNT >= (32'd1 << CW)) || (REP_DLY >= (32'd1 << CW)) ||
        (REP_PER >= (32'd1 << CW))) begin : g_param_err
        $error("motor602_cmd_cond: illegal parameter combination");
    end

    logic [NCH-1:0] raw_s;
    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    logic [NCH-1:0] st_s;
    logic [3:0]     st_prev_q;
    logic [3:0]     rise_s;
    logic [3:0]     pulse_s;

    assign raw_s = {m3powerDECi, m3powerINCi, m3freqDECi, m3freqINCi,
                    m3invRotateI, m3forceStopI, m3startI};

    // Two-flop synchroniser for every raw command
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            sync1_q <= {NCH{1'b0}};
            sync2_q <= {NCH{1'b0}};
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_deb
        logic [CW-1:0] dc_q;
        logic [CW-1:0] dc_d;
        logic          st_q;
        logic          st_d;

        // Accept a new level only after DEB_CNT consecutive disagreeing samples
        always_comb begin
            st_d = st_q;
            dc_d = {CW{1'b0}};
            if (sync2_q[g] != st_q) begin
                if (dc_q == CW'(DEB_CNT - 32'd1)) begin
                    st_d = sync2_q[g];
                    dc_d = {CW{1'b0}};
                end else begin
                    dc_d = dc_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end else begin
                dc_d = {CW{1'b0}};
            end
        end

        // Debounce state and counter
        always_ff @(posedge clkI or posedge rstI) begin
            if (rstI) begin
                st_q <= 1'b0;
                dc_q <= {CW{1'b0}};
            end else begin
                st_q <= st_d;
                dc_q <= dc_d;
            end
        end

        assign st_s[g] = st_q;
    end

    assign rise_s = st_s[NCH-1:CH_FINC] & ~st_prev_q;

    for (genvar p = 0; p < 2; p++) begin : g_pair
        pair_state_e state_q;
        pair_state_e state_d;
        logic        dir_q;
        logic        dir_d;
        logic        inc_p_s;
        logic        dec_p_s;
        logic        inc_lvl_s;
        logic        dec_lvl_s;
        logic        held_s;
`ifdef MOTOR602_CMD_AUTOREPEAT_EN
        logic [CW-1:0] rc_q;
        logic [CW-1:0] rc_d;
`endif

        assign inc_lvl_s = st_s[CH_FINC + 2*p];
        assign dec_lvl_s = st_s[CH_FINC + 2*p + 1];
        // dir_q: 0 = INC owns the pair, 1 = DEC owns it
        assign held_s    = dir_q ? dec_lvl_s : inc_lvl_s;

        // Pair arbitration: forceStop and INC+DEC conflict both reset to idle
        always_comb begin
            state_d = state_q;
            dir_d   = dir_q;
            inc_p_s = 1'b0;
            dec_p_s = 1'b0;
`ifdef MOTOR602_CMD_AUTOREPEAT_EN
            rc_d    = rc_q;
`endif
            if (st_s[CH_FSTOP] || (inc_lvl_s && dec_lvl_s)) begin
                state_d = ST_IDLE;
`ifdef MOTOR602_CMD_AUTOREPEAT_EN
                rc_d    = {CW{1'b0}};
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise_s[2*p]) begin
                            inc_p_s = 1'b1;
                            dir_d   = 1'b0;
                            state_d = ST_FIRST;
                        end else if (rise_s[2*p+1]) begin
                            dec_p_s = 1'b1;
                            dir_d   = 1'b1;
                            state_d = ST_FIRST;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_FIRST: begin
                        if (!held_s) begin
                            state_d = ST_IDLE;
                        end else begin
`ifdef MOTOR602_CMD_AUTOREPEAT_EN
                            state_d = ST_WAIT_DLY;
                            rc_d    = {{(CW-1){1'b0}}, 1'b1};
`else
                            state_d = ST_FIRST;
`endif
                        end
                    end
`ifdef MOTOR602_CMD_AUTOREPEAT_EN
                    ST_WAIT_DLY: begin
                        if (!held_s) begin
                            state_d = ST_IDLE;
                            rc_d    = {CW{1'b0}};
                        end else if (rc_q == CW'(REP_DLY - 32'd1)) begin
                            inc_p_s = ~dir_q;
                            dec_p_s = dir_q;
                            state_d = ST_REPEAT;
                            rc_d    = {CW{1'b0}};
                        end else begin
                            rc_d    = rc_q + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_REPEAT: begin
                        if (!held_s) begin
                            state_d = ST_IDLE;
                            rc_d    = {CW{1'b0}};
                        end else if (rc_q == CW'(REP_PER - 32'd1)) begin
                            inc_p_s = ~dir_q;
                            dec_p_s = dir_q;
                            rc_d    = {CW{1'b0}};
                        end else begin
                            rc_d    = rc_q + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
`endif
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end

        // Pair state register
        always_ff @(posedge clkI or posedge rstI) begin
            if (rstI) begin
                state_q <= ST_IDLE;
                dir_q   <= 1'b0;
`ifdef MOTOR602_CMD_AUTOREPEAT_EN
                rc_q    <= {CW{1'b0}};
`endif
            end else begin
                state_q <= state_d;
                dir_q   <= dir_d;
`ifdef MOTOR602_CMD_AUTOREPEAT_EN
                rc_q    <= rc_d;
`endif
            end
        end

        assign pulse_s[2*p]   = inc_p_s;
        assign pulse_s[2*p+1] = dec_p_s;
    end

    // Registered command outputs and edge-detect history
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            m3startO     <= 1'b0;
            m3forceStopO <= 1'b0;
            m3invRotateO <= 1'b0;
            m3freqINCo   <= 1'b0;
            m3freqDECo   <= 1'b0;
            m3powerINCo  <= 1'b0;
            m3powerDECo  <= 1'b0;
            st_prev_q    <= 4'd0;
        end else begin
            m3startO     <= st_s[CH_START] & ~st_s[CH_FSTOP];
            m3forceStopO <= st_s[CH_FSTOP];
            m3invRotateO <= st_s[CH_INV];
            m3freqINCo   <= pulse_s[0];
            m3freqDECo   <= pulse_s[1];
            m3powerINCo  <= pulse_s[2];
            m3powerDECo  <= pulse_s[3];
            st_prev_q    <= st_s[NCH-1:CH_FINC];
        end
    end

endmodule

// File: tb/tb_motor602_cmd_cond.sv
// Randomised bench for motor602_cmd_cond against a behavioural command-conditioning model.
module tb_motor602_cmd_cond;

    localparam int DEB_CNT = 4;
    localparam int REP_DLY = 20;
    localparam int REP_PER = 8;
`ifdef MOTOR602_CMD_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_r = 1'b1;
    logic [6:0] raw_r = 7'd0;
    logic [6:0] dut_out;
    logic       start_o, fstop_o, inv_o, finc_o, fdec_o, pinc_o, pdec_o;

    always #5 clk = ~clk;

    motor602_cmd_cond #(.DEB_CNT(DEB_CNT), .REP_DLY(REP_DLY), .REP_PER(REP_PER), .CW(8)) dut (
        .clkI(clk), .rstI(rst_r),
        .m3startI(raw_r[0]), .m3forceStopI(raw_r[1]), .m3invRotateI(raw_r[2]),
        .m3freqINCi(raw_r[3]), .m3freqDECi(raw_r[4]), .m3powerINCi(raw_r[5]), .m3powerDECi(raw_r[6]),
        .m3startO(start_o), .m3forceStopO(fstop_o), .m3invRotateO(inv_o),
        .m3freqINCo(finc_o), .m3freqDECo(fdec_o), .m3powerINCo(pinc_o), .m3powerDECo(pdec_o)
    );

    assign dut_out = {pdec_o, pinc_o, fdec_o, finc_o, inv_o, fstop_o, start_o};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: synchroniser delay, run-length debounce, press bookkeeping per pair
    bit [6:0] m_s1, m_s2, m_st, m_stp, m_out;
    int       m_run [7];
    int       m_act [2];   // 0 none, 1 INC owns, 2 DEC owns
    int       m_t0  [2];
    int       m_edge = 0;

    task automatic model_edge(input logic [6:0] raw_v, input logic rst_v);
        bit [6:0] rise;
        bit [6:0] nxt;
        if (rst_v) begin
            m_s1 = 7'd0; m_s2 = 7'd0; m_st = 7'd0; m_stp = 7'd0; m_out = 7'd0;
            for (int c = 0; c < 7; c++) m_run[c] = 0;
            m_act[0] = 0; m_act[1] = 0;
        end else begin
            m_edge++;
            rise  = m_st & ~m_stp;
            m_out = 7'd0;
            m_out[0] = m_st[0] & ~m_st[1];
            m_out[1] = m_st[1];
            m_out[2] = m_st[2];
            for (int p = 0; p < 2; p++) begin
                int i;
                int k;
                i = 3 + 2 * p;
                if (m_st[1] || (m_st[i] && m_st[i+1]) ||
                    (m_act[p] == 1 && !m_st[i]) || (m_act[p] == 2 && !m_st[i+1])) begin
                    m_act[p] = 0;
                end else if (m_act[p] == 0) begin
                    if (rise[i]) begin
                        m_out[i] = 1'b1; m_act[p] = 1; m_t0[p] = m_edge;
                    end else if (rise[i+1]) begin
                        m_out[i+1] = 1'b1; m_act[p] = 2; m_t0[p] = m_edge;
                    end
                end else if (AUTO) begin
                    k = m_edge - m_t0[p];
                    if (k == REP_DLY || (k > REP_DLY && (k - REP_DLY) % REP_PER == 0))
                        m_out[i + m_act[p] - 1] = 1'b1;
                end
            end
            m_stp = m_st;
            nxt   = m_st;
            for (int c = 0; c < 7; c++) begin
                if (m_s2[c] != m_st[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB_CNT) begin
                        nxt[c]   = m_s2[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_st = nxt;
            m_s2 = m_s1;
            m_s1 = raw_v;
        end
    endtask

    task automatic step(input logic [6:0] raw_v, input logic rst_v);
        raw_r = raw_v;
        rst_r = rst_v;
        @(posedge clk);
        model_edge(raw_v, rst_v);
        @(negedge clk);
        cyc++;
        check_val("outs", {25'd0, dut_out}, {25'd0, m_out});
    endtask

    initial begin
        int first;
        int last;
        int cnt;
        int rst_left;
        logic [6:0] rnd;

        for (int k = 0; k < 3; k++) begin
            step(7'd0, 1'b1);
            check_val("reset", {25'd0, dut_out}, 32'd0);
        end
        for (int k = 0; k < 8; k++) step(7'd0, 1'b0);

        // Clean freqINC press: one pulse, DEB_CNT+3 edges after the raw step
        first = 0; cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            step(7'b0001000, 1'b0);
            if (finc_o) begin cnt++; if (first == 0) first = k; end
        end
        check_val("finc_first", 32'(first), 32'd7);
        check_val("finc_count", 32'(cnt), 32'd1);
        for (int k = 0; k < 12; k++) step(7'd0, 1'b0);

        // Short powerDEC glitches never survive debounce
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step((k % 4 != 3) ? 7'b1000000 : 7'd0, 1'b0);
            if (pdec_o) cnt++;
        end
        for (int k = 0; k < 10; k++) begin
            step(7'd0, 1'b0);
            if (pdec_o) cnt++;
        end
        check_val("glitch_pulses", 32'(cnt), 32'd0);

        // powerINC held 60 cycles: auto-repeat train or single pulse
        cnt = 0; last = 0;
        for (int k = 1; k <= 60; k++) begin
            step(7'b0100000, 1'b0);
            if (pinc_o) begin cnt++; last = k; end
        end
        check_val("pinc_count", 32'(cnt), AUTO ? 32'd6 : 32'd1);
        check_val("pinc_last", 32'(last), AUTO ? 32'd59 : 32'd7);
        for (int k = 0; k < 14; k++) step(7'd0, 1'b0);

        // Reset in the middle of a held freqDEC, then a fresh pulse after release
        for (int k = 0; k < 20; k++) step(7'b0010000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(7'b0010000, 1'b1);
            check_val("rst_hold", {25'd0, dut_out}, 32'd0);
        end
        first = 0; cnt = 0;
        for (int k = 1; k <= 15; k++) begin
            step(7'b0010000, 1'b0);
            if (fdec_o) begin cnt++; if (first == 0) first = k; end
        end
        check_val("fdec_after_rst", 32'(first), 32'd7);
        check_val("fdec_rst_count", 32'(cnt), 32'd1);
        for (int k = 0; k < 12; k++) step(7'd0, 1'b0);

        // Random segments: slow, glitchy, long holds without forceStop, mixed
        rnd = 7'd0; rst_left = 0;
        for (int n = 0; n < 3000; n++) begin
            int seg;
            seg = (n / 300) % 4;
            for (int c = 0; c < 7; c++) begin
                int thr;
                if (c == 1)        thr = 150;
                else if (seg == 1) thr = 3;
                else if (seg == 2) thr = (c >= 3) ? 60 : 20;
                else               thr = (c >= 3) ? 40 : 20;
                if ($urandom_range(thr - 1, 0) == 0) rnd[c] = ~rnd[c];
            end
            if (seg == 2) rnd[1] = 1'b0;
            if (rst_left == 0 && $urandom_range(599, 0) == 0) rst_left = 3;
            step(rnd, rst_left > 0);
            if (rst_left > 0) rst_left--;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/motor602_cmd_cond.md
Name: motor602_cmd_cond

Overview:
- Command-conditioning stage directly upstream of the motor602 core, in clkI domain (10 MHz).
- Conditions the seven raw panel/button commands: 2-FF synchroniser, per-channel counter debounce, then level or pulse formatting.
- Applies forceStop priority and INC/DEC mutual exclusion.
- Outputs replace the plain input register and drive the core's m3* command inputs directly.

Parameters:
- DEB_CNT, 200000: consecutive stable cycles required to accept a level change (20 ms at 10 MHz); must be >=2.
- REP_DLY, 5000000: cycles from first INC/DEC pulse to first auto-repeat pulse (0.5 s).
- REP_PER, 1000000: cycles between subsequent auto-repeat pulses (0.1 s).
- CW, 23: width of debounce and repeat counters; must hold max(DEB_CNT, REP_DLY, REP_PER).

Ports:
- clkI  in  1  system clock, 10 MHz.
- rstI  in  1  asynchronous, active-high reset.
- m3startI  in  1  raw start button, async.
- m3forceStopI  in  1  raw force-stop button, async.
- m3invRotateI  in  1  raw rotation-direction switch, async.
- m3freqINCi  in  1  raw frequency-increase button.
- m3freqDECi  in  1  raw frequency-decrease button.
- m3powerINCi  in  1  raw power-increase button.
- m3powerDECi  in  1  raw power-decrease button.
- m3startO  out  1  debounced start level, forced 0 while forceStop is active.
- m3forceStopO  out  1  debounced force-stop level.
- m3invRotateO  out  1  debounced direction level.
- m3freqINCo  out  1  one-cycle increment pulse.
- m3freqDECo  out  1  one-cycle decrement pulse.
- m3powerINCo  out  1  one-cycle increment pulse.
- m3powerDECo  out  1  one-cycle decrement pulse.

Behaviour:
- Reset (async, rstI=1):
  - Sync flops, debounced state, counters and all outputs go to 0.
  - Assertion mid-operation aborts any debounce or repeat in progress immediately.
- Synchroniser: 2 FF per input. Raw edge appears on sync2 at the 2nd clkI edge.
- Debounce, per channel:
  - State register st and counter dc.
  - sync2 != st: dc increments. On the cycle dc == DEB_CNT-1, st <= sync2 and dc <= 0.
  - sync2 == st: dc <= 0. Any glitch shorter than DEB_CNT cycles restarts the count.
- Latency: for a clean raw step, st changes DEB_CNT+2 cycles after the raw change.
- Level outputs are registered from st, adding 1 cycle:
  - m3startO = st_start & ~st_forceStop.
  - m3forceStopO = st_forceStop.
  - m3invRotateO = st_invRotate.
- Pulse outputs: rising edge of st generates a 1-cycle pulse, registered, same cycle as a level output would change. Falling edges generate nothing.
- Pair exclusion (freq pair, power pair independently):
  - Both debounced highs active: no pulses; the pair's repeat timer is cleared.
  - When one of them is released, the remaining one does NOT pulse; a fresh rising edge is needed.
- Same-cycle rising edges of INC and DEC: both suppressed.
- forceStop priority: while st_forceStop=1, all four pulse outputs are held 0 and repeat timers are cleared. Rising edges that occur during forceStop are discarded, not queued.
- Power-up with a button already held: st starts 0, so a held button is accepted after debounce and produces one pulse. This is intentional.
- Pair-internal FSM, per pair: IDLE -> FIRST (pulse issued) -> WAIT_DLY -> REPEAT; any release, conflict or forceStop returns it to IDLE.

Optional Feature:
- Macro: MOTOR602_CMD_AUTOREPEAT_EN.
- Defined:
  - While an INC/DEC level stays held alone, a second pulse fires REP_DLY cycles after the first.
  - Further pulses fire every REP_PER cycles until release.
  - The repeat counter runs only in WAIT_DLY/REPEAT.
- Undefined:
  - Exactly one pulse per debounced press.
  - Repeat counters and the WAIT_DLY/REPEAT states are not built.
  - REP_DLY and REP_PER are ignored.

Test Plan (DEB_CNT=4, REP_DLY=20, REP_PER=8):
- Raw m3freqINCi 0->1 at cycle 0, held 10 cycles -> single m3freqINCo pulse at cycle 7 (DEB_CNT+2 = 6, plus 1 output register), 1 cycle wide; release produces no pulse.
- m3powerDECi toggled with 3-cycle highs separated by 1-cycle lows for 30 cycles -> m3powerDECo never asserts; debounced state remains 0.
- m3startI held high, then m3forceStopI pressed -> m3startO=1. 7 cycles after the forceStop raw edge, m3forceStopO=1 and m3startO=0. INC presses during forceStop give no pulses.
- m3freqINCi and m3freqDECi raised same cycle and held, then DEC released -> no pulses on either output at any point.
- AUTOREPEAT_EN defined, m3powerINCi held 60 cycles -> pulses at cycles 7, 27, 35, 43, 51, 59; none after release. Macro undefined -> only cycle 7.
- Button held, rstI pulsed for 3 cycles mid-hold -> all outputs 0 during reset; one new pulse 7 cycles after reset release.
